fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the fetch unit and the decode stage.
- Captures each 9-bit instruction together with its 8-bit program counter from fetch, and presents them in order to decode using a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered (wrong-path) instructions when a taken branch or overflow redirect asserts flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- IW, 9, instruction width in bits.
- PW, 8, program counter width in bits.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears the queue immediately.
- flush  input  1  synchronous; empties the queue at the next edge.
- in_valid  input  1  fetch presents an instruction this cycle.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- in_instruction  input  IW  instruction word from fetch.
- in_pc  input  PW  PC of in_instruction.
- out_valid  output  1  head entry is available to decode; equals (count != 0).
- out_ready  input  1  decode consumes the head this cycle.
- out_instruction  output  IW  head instruction word; all-zero when empty.
- out_pc  output  PW  head PC; all-zero when empty.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each holding {instruction, pc}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is a separate register, 0..DEPTH.
- Reset:
  - Asynchronous.
  - Sets write pointer, read pointer and count to 0.
  - Outputs immediately become: out_valid=0, in_ready=1, out_instruction=0, out_pc=0, count=0.
  - Entry contents need not be cleared.
  - Reset asserted mid-operation discards all entries with no further handshake.
- Push: occurs at a rising edge when in_valid && in_ready && !flush.
  - Writes {in_instruction, in_pc} to the write-pointer slot.
  - Write pointer increments by 1.
- Pop: occurs at a rising edge when out_valid && out_ready && !flush.
  - Read pointer increments by 1.
- Count update:
  - Push only: count increments by 1.
  - Pop only: count decrements by 1.
  - Push and pop in the same cycle: count unchanged.
  - Simultaneous push/pop is legal whenever 0 < count < DEPTH.
- Full (count == DEPTH):
  - in_ready=0 and no push occurs, even if out_ready=1 the same cycle (no pass-through).
  - A pop lowers count, so in_ready=1 on the following cycle.
- Empty (count == 0):
  - out_valid=0 and out_ready is ignored.
  - A push in this cycle makes the entry visible on out_* from the next cycle; fall-through latency is 1 cycle.
- Head outputs:
  - Combinationally read from the read-pointer slot, gated to zero when empty.
  - out_* must not change while out_valid=1 && out_ready=0.
- Flush:
  - Highest synchronous priority.
  - At the edge: both pointers go to 0 and count goes to 0.
  - Any push or pop offered in the same cycle is dropped.
  - out_valid=0 from the next cycle.
  - in_ready stays 1 through the flush cycle whenever count < DEPTH.
- Ordering:
  - Strict FIFO; PCs leave in the same order they entered.
  - No reordering and no duplication.
- Invariants, checked as assertions in simulation:
  - count never exceeds DEPTH.
  - count never underflows.
  - (write pointer − read pointer) mod DEPTH equals count mod DEPTH.

Test Plan:
- Reset then fill: assert reset, release, then push PCs 0x00..0x03 with instructions 0x101..0x104 and out_ready=0.
  - count goes 1,2,3,4.
  - in_ready=0 after the 4th push.
  - A 5th push (PC 0x04) is refused and count stays 4.
- Drain order: from full, hold out_ready=1 for 4 cycles.
  - out_pc reads 0x00,0x01,0x02,0x03 and out_instruction reads 0x101..0x104.
  - Then out_valid=0, count=0, out_instruction=0.
- Streaming wrap: push and pop in the same cycle for 10 cycles at count=2 (PCs 0x10..0x19).
  - count stays 2 throughout.
  - Pointers wrap at least twice.
  - Output sequence equals input sequence delayed by 2 entries.
- Flush collision: at count=3, assert flush with in_valid=1 (PC 0x40) and out_ready=1 together.
  - Next cycle: count=0, out_valid=0.
  - PC 0x40 is never output.
  - A following push of PC 0x41 appears on out_pc one cycle later.
- Full with out_ready: at count=4, assert in_valid=1 (PC 0x50) and out_ready=1.
  - Pop occurs and push is refused; count=3 next cycle.
  - in_ready=1 next cycle; the retry of PC 0x50 is accepted.
- Async reset mid-stream: at count=2, assert reset between clock edges.
  - Outputs clear immediately without waiting for an edge: out_valid=0, count=0.
  - After release, the first pushed PC 0x60 is the first PC output.

Source files
------------

// File: rtl/fetch_queue.sv
// Purpose     : in-order instruction prefetch buffer between fetch and decode, entries are {instruction, pc}.
// Latency     : 1 cycle fall-through (push at edge N is visible on out_* after edge N); head read combinationally.
// Backpressure: in_ready drops when full (no pass-through on a full+pop cycle); flush drops all entries and same-cycle push/pop.
//
// Ports:
//   clock, reset (async, active-high), flush (sync, highest priority)
//   in_valid/in_ready/in_instruction/in_pc    : fetch side
//   out_valid/out_ready/out_instruction/out_pc : decode side, out_* zeroed when empty
//   count                                      : occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int PW    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IW-1:0]              in_instruction,
    input  logic [PW-1:0]              in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IW-1:0]              out_instruction,
    output logic [PW-1:0]              out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [IW-1:0] instruction;
        logic [PW-1:0] pc;
    } entry_t;

    // Entry storage carries no reset; only pointers and count define validity.
    entry_t          mem_q [DEPTH];
    entry_t          wr_entry_d;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            push;
    logic            pop;
    entry_t          head;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush overrides both handshakes, so neither side sees a transfer that cycle.
    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign head            = mem_q[rd_ptr_q];
    assign out_instruction = out_valid ? head.instruction : '0;
    assign out_pc          = out_valid ? head.pc          : '0;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wr_entry_d = '{instruction: in_instruction, pc: in_pc};

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    // Occupancy invariants; an underflow wraps count above DEPTH and trips the first check.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CW'(DEPTH))
                else $error("fetch_queue: count %0d exceeds DEPTH", count_q);
            assert (AW'(wr_ptr_q - rd_ptr_q) == count_q[AW-1:0])
                else $error("fetch_queue: pointer distance disagrees with count %0d", count_q);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose     : directed bench for fetch_queue with an expected-entry scoreboard and occupancy model.
// Latency     : every step is one clock; checks land 2 time units after the rising edge.
// Backpressure: the bench decides acceptance from its own occupancy model, not from the DUT.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int IW    = 9;
    localparam int PW    = 8;

    typedef struct packed {
        logic [IW-1:0] ins;
        logic [PW-1:0] pc;
    } ent_t;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instruction;
    logic [PW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instruction;
    logic [PW-1:0] out_pc;
    logic [2:0]    count;

    ent_t sb[$];
    int   mdl_cnt;
    int   compared;
    int   mismatched;

    fetch_queue #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .count           (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
            else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // One clock of stimulus: drive, check against the model, predict the edge, advance.
    task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                         input logic rdy, input logic fl);
        bit   m_push;
        bit   m_pop;
        ent_t e;
        in_valid       = v;
        in_instruction = ins;
        in_pc          = pc;
        out_ready      = rdy;
        flush          = fl;
        #1;
        check("count",     16'(count),     16'(mdl_cnt));
        check("in_ready",  16'(in_ready),  16'(mdl_cnt < DEPTH));
        check("out_valid", 16'(out_valid), 16'(mdl_cnt != 0));
        if (mdl_cnt != 0) begin
            check("head_pc",  16'(out_pc),          16'(sb[0].pc));
            check("head_ins", 16'(out_instruction), 16'(sb[0].ins));
        end else begin
            check("empty_pc",  16'(out_pc),          16'h0);
            check("empty_ins", 16'(out_instruction), 16'h0);
        end
        m_push = v && (mdl_cnt < DEPTH) && !fl;
        m_pop  = rdy && (mdl_cnt != 0) && !fl;
        if (fl) begin
            sb.delete();
            mdl_cnt = 0;
        end else begin
            if (m_pop) begin
                e = sb.pop_front();
                mdl_cnt--;
            end
            if (m_push) begin
                e.ins = ins;
                e.pc  = pc;
                sb.push_back(e);
                mdl_cnt++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        mdl_cnt        = 0;
        reset          = 1'b1;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc          = '0;
        out_ready      = 1'b0;

        #2;
        check("rst_count",     16'(count),     16'h0);
        check("rst_in_ready",  16'(in_ready),  16'h1);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_pc",    16'(out_pc),    16'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset then fill, fifth push refused.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, IW'(9'h101 + i), PW'(i), 1'b0, 1'b0);
            check("fill_count", 16'(count), 16'(i + 1));
        end
        check("full_in_ready", 16'(in_ready), 16'h0);
        cycle(1'b1, 9'h105, 8'h04, 1'b0, 1'b0);
        check("refused_count", 16'(count), 16'h4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("drained_valid", 16'(out_valid),       16'h0);
        check("drained_count", 16'(count),           16'h0);
        check("drained_ins",   16'(out_instruction), 16'h0);

        // Streaming at count 2 across several pointer wraps.
        cycle(1'b1, 9'h110, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 9'h111, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("stream_pc", 16'(out_pc), 16'(8'h10 + i));
            cycle(1'b1, IW'(9'h112 + i), PW'(8'h12 + i), 1'b1, 1'b0);
            check("stream_count", 16'(count), 16'h2);
        end

        // Flush colliding with push and pop at count 3.
        cycle(1'b1, 9'h120, 8'h20, 1'b0, 1'b0);
        check("pre_flush_count", 16'(count), 16'h3);
        cycle(1'b1, 9'h140, 8'h40, 1'b1, 1'b1);
        check("flush_count", 16'(count),     16'h0);
        check("flush_valid", 16'(out_valid), 16'h0);
        cycle(1'b1, 9'h141, 8'h41, 1'b0, 1'b0);
        check("post_flush_pc", 16'(out_pc), 16'h41);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Full with out_ready: pop happens, push refused, retry accepted.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, IW'(9'h130 + i), PW'(8'h30 + i), 1'b0, 1'b0);
        end
        cycle(1'b1, 9'h150, 8'h50, 1'b1, 1'b0);
        check("full_pop_count", 16'(count),    16'h3);
        check("full_pop_ready", 16'(in_ready), 16'h1);
        cycle(1'b1, 9'h150, 8'h50, 1'b0, 1'b0);
        check("retry_count", 16'(count), 16'h4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges at count 2.
        cycle(1'b1, 9'h158, 8'h58, 1'b0, 1'b0);
        cycle(1'b1, 9'h159, 8'h59, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_arst_count", 16'(count), 16'h2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid",    16'(out_valid), 16'h0);
        check("arst_count",    16'(count),     16'h0);
        check("arst_in_ready", 16'(in_ready),  16'h1);
        check("arst_pc",       16'(out_pc),    16'h0);
        sb.delete();
        mdl_cnt = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b1, 9'h160, 8'h60, 1'b0, 1'b0);
        check("first_after_arst", 16'(out_pc), 16'h60);
        cycle(1'b1, 9'h161, 8'h61, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("final_sb_empty", 16'(sb.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
